// File: rtl/ipv4_checksum_inserter.sv
// ipv4_checksum_inserter: fills in the IPv4 header checksum on a 64-bit AXI4-Stream egress path.
// Ports: axi_aclk/axi_reset (sync, active-high); s_axis_* ingress (tdata/tstrb/tuser/tlast/tvalid, tready out);
// m_axis_* egress (tdata/tstrb/tuser/tlast/tvalid out, tready in); csum_done pulses when beat 3 leaves with a new checksum.
// Option: define IPV4_TTL_DECREMENT_EN to decrement a nonzero TTL on rewritten frames.
module ipv4_checksum_inserter #(
  parameter int C_S_AXIS_TDATA_WIDTH = 64,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              csum_done
);
  typedef enum logic [1:0] {COLLECT, DRAIN, PASS} state_t;
  state_t state, state_n;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   bd [5];
  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] bs [5];
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   bu [5];
  logic [4:0] bl;
  logic [2:0] cnt, rd, k;
  logic ins, s_fire, m_fire, ld, use_in, last_st;
  logic [7:0] ttl;
  logic [31:0] sum;
  logic [16:0] f1;
  logic [15:0] csum;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   ld_d;
  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] ld_s;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ld_u;
  logic                              ld_l;
  function automatic logic [31:0] wd(input logic [63:0] d, input int i);
    return {16'h0, d[16*i+:8], d[16*i+8+:8]};
  endfunction
  assign s_fire = s_axis_tvalid & s_axis_tready;
  assign m_fire = m_axis_tvalid & m_axis_tready;
  assign last_st = rd == cnt - 3'd1;
`ifdef IPV4_TTL_DECREMENT_EN
  assign ttl = bd[2][55:48] - {7'd0, |bd[2][55:48]};
`else
  assign ttl = bd[2][55:48];
`endif
  // the checksum field (beat 3 word 0) is left out, i.e. counted as zero
  assign sum = wd(bd[1], 3) + wd(bd[2], 0) + wd(bd[2], 1) + wd(bd[2], 2) + {16'h0, ttl, bd[2][63:56]}
             + wd(bd[3], 1) + wd(bd[3], 2) + wd(bd[3], 3) + wd(bd[4], 0);
  assign f1 = {1'b0, sum[31:16]} + {1'b0, sum[15:0]};
  assign csum = ~(f1[15:0] + {15'd0, f1[16]});
  assign csum_done = ~axi_reset & ins & m_fire & (state == DRAIN) & (rd == 3'd3);
  always_comb begin
    state_n = state;
    s_axis_tready = 1'b0;
    case (state)
      COLLECT: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && (s_axis_tlast || cnt == 3'd4)) state_n = DRAIN;
      end
      DRAIN: if (m_fire && last_st) state_n = m_axis_tlast ? COLLECT : PASS;
      default: begin
        // stop taking beats once the frame's tlast sits in the output register
        s_axis_tready = ~m_axis_tvalid | (m_axis_tready & ~m_axis_tlast);
        if (m_fire && m_axis_tlast) state_n = COLLECT;
      end
    endcase
    if (axi_reset) s_axis_tready = 1'b0;
  end
  always_comb begin
    k = state == DRAIN ? rd + 3'd1 : 3'd0;
    use_in = state == PASS || cnt == 3'd0;
    ld = state == COLLECT ? s_fire && (s_axis_tlast || cnt == 3'd4)
       : state == DRAIN ? m_fire && !last_st : s_fire;
    ld_d = use_in ? s_axis_tdata : bd[k];
    ld_s = use_in ? s_axis_tstrb : bs[k];
    ld_u = use_in ? s_axis_tuser : bu[k];
    ld_l = use_in ? s_axis_tlast : bl[k];
    if (ins && k == 3'd2) ld_d[55:48] = ttl;
    if (ins && k == 3'd3) ld_d[15:0] = {csum[7:0], csum[15:8]};
  end
  always_ff @(posedge axi_aclk)
    if (state == COLLECT && s_fire) begin
      bd[cnt] <= s_axis_tdata;
      bs[cnt] <= s_axis_tstrb;
      bu[cnt] <= s_axis_tuser;
      bl[cnt] <= s_axis_tlast;
    end
  always_ff @(posedge axi_aclk)
    if (axi_reset) begin
      state <= COLLECT;
      cnt <= 3'd0;
      rd <= 3'd0;
      ins <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tstrb <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      state <= state_n;
      if (state == COLLECT && s_fire) begin
        cnt <= cnt + 3'd1;
        ins <= cnt == 3'd4 && {bd[1][39:32], bd[1][47:40]} == 16'h0800 && bd[1][55:48] == 8'h45;
      end else if (state != COLLECT && state_n == COLLECT) cnt <= 3'd0;
      rd <= state == COLLECT ? 3'd0 : rd + {2'd0, state == DRAIN && m_fire};
      if (ld) begin
        m_axis_tdata <= ld_d;
        m_axis_tstrb <= ld_s;
        m_axis_tuser <= ld_u;
        m_axis_tlast <= ld_l;
      end
      m_axis_tvalid <= ld | (m_axis_tvalid & ~m_axis_tready);
    end
endmodule

// File: tb/tb_ipv4_checksum_inserter.sv
// tb_ipv4_checksum_inserter: scoreboard bench for ipv4_checksum_inserter.
module tb_ipv4_checksum_inserter;
  logic axi_aclk = 1'b0;
  logic axi_reset = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0] s_axis_tstrb = '0;
  logic [127:0] s_axis_tuser = '0;
  logic s_axis_tlast = 1'b0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0] m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic m_axis_tlast, m_axis_tvalid, csum_done;
  logic m_axis_tready = 1'b1;
`ifdef IPV4_TTL_DECREMENT_EN
  localparam logic [15:0] CS_A = 16'hb961;
  localparam logic [7:0] TTL_A = 8'h3f;
`else
  localparam logic [15:0] CS_A = 16'hb861;
  localparam logic [7:0] TTL_A = 8'h40;
`endif
  typedef struct {
    logic [63:0] d;
    logic [7:0] s;
    logic [127:0] u;
    logic l;
    logic dn;
  } exp_t;
  exp_t sbq[$];
  logic [7:0] fb [0:127];
  logic [7:0] efb [0:127];
  logic [7:0] fs [0:15];
  logic [127:0] fu [0:15];
  int n_chk = 0, n_fail = 0, done_cnt = 0, mon_idx = 0;
  bit rnd_ready = 1'b0;
  logic [15:0] got_csum;
  logic [7:0] got_ttl;
  logic stalled = 1'b0;
  logic [200:0] held;
  ipv4_checksum_inserter dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .csum_done(csum_done)
  );
  always #5 axi_aclk = ~axi_aclk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic build(input int nb, input logic [15:0] et, input logic [7:0] vi, input logic [7:0] ttl, input bit ex);
    logic [159:0] hx;
    hx = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;
    for (int i = 0; i < 128; i++) fb[i] = 8'($urandom);
    for (int b = 0; b < 16; b++) begin
      fs[b] = 8'($urandom);
      fu[b] = {$urandom, $urandom, $urandom, $urandom};
    end
    if (ex) for (int i = 1; i < 20; i++) fb[14+i] = hx[159-8*i -: 8];
    fb[12] = et[15:8];
    fb[13] = et[7:0];
    fb[14] = vi;
    fb[22] = ttl;
  endtask
  function automatic void push_exp(input int nb);
    exp_t e;
    logic [31:0] s;
    logic [15:0] c;
    bit ins;
    for (int i = 0; i < 128; i++) efb[i] = fb[i];
    ins = nb >= 5 && fb[12] == 8'h08 && fb[13] == 8'h00 && fb[14] == 8'h45;
    if (ins) begin
`ifdef IPV4_TTL_DECREMENT_EN
      if (efb[22] != 8'h00) efb[22] = efb[22] - 8'h01;
`endif
      s = 32'h0;
      for (int i = 14; i < 34; i += 2) if (i != 24) s += {16'h0, efb[i], efb[i+1]};
      while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      c = ~s[15:0];
      efb[24] = c[15:8];
      efb[25] = c[7:0];
    end
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 8; j++) e.d[8*j+:8] = efb[8*b+j];
      e.s = fs[b];
      e.u = fu[b];
      e.l = b == nb - 1;
      e.dn = ins && b == 3;
      sbq.push_back(e);
    end
  endfunction
  task automatic send(input int nb, input bit gap, input int stop_at);
    int t;
    push_exp(nb);
    for (int b = 0; b < stop_at; b++) begin
      if (gap && $urandom_range(0, 2) == 0) begin
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b0;
      end
      @(negedge axi_aclk);
      s_axis_tvalid = 1'b1;
      for (int j = 0; j < 8; j++) s_axis_tdata[8*j+:8] = fb[8*b+j];
      s_axis_tstrb = fs[b];
      s_axis_tuser = fu[b];
      s_axis_tlast = b == nb - 1;
      #1;
      t = 0;
      while (!s_axis_tready && t < 500) begin
        @(negedge axi_aclk);
        #1;
        t++;
      end
      chk("accept", s_axis_tready, 1);
      if (!s_axis_tready) break;
    end
    @(negedge axi_aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask
  task automatic wait_empty();
    int t = 0;
    while (sbq.size() != 0 && t < 5000) begin
      @(negedge axi_aclk);
      t++;
    end
    chk("drain", sbq.size(), 0);
    repeat (2) @(negedge axi_aclk);
  endtask
  initial forever begin
    @(negedge axi_aclk);
    m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial forever begin
    exp_t e;
    @(negedge axi_aclk);
    #1;
    if (axi_reset) begin
      stalled = 1'b0;
      mon_idx = 0;
    end else begin
      if (stalled) chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast}, {1'b1, held});
      if (m_axis_tvalid && m_axis_tready) begin
        if (sbq.size() == 0) chk("unexpected_beat", m_axis_tvalid, 0);
        else begin
          e = sbq.pop_front();
          chk("data", m_axis_tdata, e.d);
          chk("strb", m_axis_tstrb, e.s);
          chk("user", m_axis_tuser, e.u);
          chk("last", m_axis_tlast, e.l);
          chk("done", csum_done, e.dn);
        end
        if (mon_idx == 2) got_ttl = m_axis_tdata[55:48];
        if (mon_idx == 3) got_csum = {m_axis_tdata[7:0], m_axis_tdata[15:8]};
        mon_idx = m_axis_tlast ? 0 : mon_idx + 1;
        done_cnt += int'(csum_done);
      end else if (csum_done) chk("done_idle", csum_done, 0);
      stalled = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge axi_aclk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_done", csum_done, 0);
    @(negedge axi_aclk);
    axi_reset = 1'b0;
    #1;
    chk("idle_tready", s_axis_tready, 1);
    build(10, 16'h0800, 8'h45, 8'h40, 1);
    done_cnt = 0;
    got_csum = 16'h0;
    send(10, 0, 10);
    wait_empty();
    chk("a_csum", got_csum, CS_A);
    chk("a_ttl", got_ttl, TTL_A);
    chk("a_done_cnt", done_cnt, 1);
    build(10, 16'h0800, 8'h45, 8'h00, 1);
    send(10, 0, 10);
    wait_empty();
    chk("ttl0", got_ttl, 8'h00);
    build(8, 16'h86dd, 8'h60, 8'h40, 0);
    done_cnt = 0;
    send(8, 0, 8);
    wait_empty();
    chk("v6_done_cnt", done_cnt, 0);
    build(9, 16'h0800, 8'h46, 8'h40, 1);
    send(9, 0, 9);
    wait_empty();
    chk("ihl6_done_cnt", done_cnt, 0);
    build(3, 16'h0800, 8'h45, 8'h40, 1);
    send(3, 0, 3);
    wait_empty();
    chk("runt_done_cnt", done_cnt, 0);
    #1;
    chk("runt_collect", s_axis_tready, 1);
    build(10, 16'h0800, 8'h45, 8'h40, 1);
    got_csum = 16'h0;
    send(10, 0, 10);
    wait_empty();
    chk("post_runt_csum", got_csum, CS_A);
    rnd_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      int nb;
      nb = $urandom_range(1, 14);
      build(nb, $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0800,
            $urandom_range(0, 4) == 0 ? 8'h46 : 8'h45, 8'($urandom), 0);
      send(nb, 1, nb);
    end
    wait_empty();
    rnd_ready = 1'b0;
    build(12, 16'h0800, 8'h45, 8'h40, 1);
    send(12, 0, 7);
    axi_reset = 1'b1;
    @(negedge axi_aclk);
    #1;
    chk("rstp_tvalid", m_axis_tvalid, 0);
    chk("rstp_tready", s_axis_tready, 0);
    axi_reset = 1'b0;
    sbq.delete();
    @(negedge axi_aclk);
    #1;
    chk("rstp_tvalid_after", m_axis_tvalid, 0);
    chk("rstp_tready_after", s_axis_tready, 1);
    build(10, 16'h0800, 8'h45, 8'h40, 1);
    got_csum = 16'h0;
    done_cnt = 0;
    send(10, 0, 10);
    wait_empty();
    chk("rstp_csum", got_csum, CS_A);
    chk("rstp_done_cnt", done_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
